puf_challenge_ctrl: RTL and testbench

PUF_CHALLENGE_CTRL -- requirements
Module: puf_challenge_ctrl

---
 rtl/puf_pkg.sv | 14 +
 rtl/sync_2ff.sv | 22 ++
 rtl/puf_challenge_ctrl.sv | 117 +++++++++++
 tb/tb_puf_challenge_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared FSM state type and default LFSR polynomial for the PUF challenge controller
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] POLY_DEFAULT = 4'hC;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops before anyone uses it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_challenge_ctrl.sv
// rtl/puf_challenge_ctrl.sv - arbiter PUF challenge sequencer collecting one R-bit response word
module puf_challenge_ctrl
  import puf_pkg::*;
#(
  parameter int             N      = 4,
  parameter int             R      = 8,
  parameter int             SETTLE = 4,
  parameter logic [N-1:0]   POLY   = N'(POLY_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] seed,
  input  logic         puf_resp,
  input  logic         resp_ready,
  output logic [N-1:0] puf_sel,
  output logic         puf_launch,
  output logic         puf_arb_reset,
  output logic         busy,
  output logic [R-1:0] resp_data,
  output logic         resp_valid
);

  // LAUNCH covers SETTLE cycles plus the two synchronizer stages
  localparam int LAUNCH_CYC = SETTLE + 2;
  localparam int SCW        = (LAUNCH_CYC > 1) ? $clog2(LAUNCH_CYC) : 1;
  localparam int BW         = (R > 1) ? $clog2(R) : 1;

  state_t         state;
  state_t         next_state;
  logic [N-1:0]   chal;
  logic [BW-1:0]  bit_cnt;
  logic [SCW-1:0] settle_cnt;
  logic           resp_sync;

  assign puf_sel = chal;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (puf_resp),
    .q       (resp_sync)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and arbiter-facing control outputs
  always_comb begin
    next_state    = state;
    puf_launch    = 1'b0;
    puf_arb_reset = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = ARM;
      end
      ARM: begin
        puf_arb_reset = 1'b1;
        next_state    = LAUNCH;
      end
      LAUNCH: begin
        puf_launch = 1'b1;
        if (settle_cnt == SCW'(LAUNCH_CYC - 1)) next_state = SAMPLE;
      end
      SAMPLE: begin
        next_state = (bit_cnt == BW'(R - 1)) ? DONE : ARM;
      end
      DONE: begin
        if (resp_valid && resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Challenge, counters and response word; the challenge only moves when the
  // launch line is low so the arbiter path is never reconfigured mid-race
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chal       <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            chal      <= (seed == '0) ? '1 : seed;
            bit_cnt   <= '0;
            resp_data <= '0;
          end
        end
        ARM: settle_cnt <= '0;
        LAUNCH: settle_cnt <= settle_cnt + SCW'(1);
        SAMPLE: begin
          resp_data[bit_cnt] <= resp_sync;
          if (bit_cnt != BW'(R - 1)) begin
            bit_cnt <= bit_cnt + BW'(1);
            chal    <= (chal >> 1) ^ (chal[0] ? POLY : '0);
          end
        end
        default: ;
      endcase
      // Valid is a flop that rises on the second DONE cycle and drops with the handshake
      resp_valid <= (state == DONE) && (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// tb/tb_puf_challenge_ctrl.sv - self-checking bench for puf_challenge_ctrl with a behavioural PUF model
module tb_puf_challenge_ctrl;

  localparam int R      = 8;
  localparam int SETTLE = 4;
  localparam int LAT    = R * (SETTLE + 4) + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] seed = 4'h0;
  logic       puf_resp = 1'b0;
  logic       resp_ready = 1'b0;
  logic [3:0] puf_sel;
  logic       puf_launch;
  logic       puf_arb_reset;
  logic       busy;
  logic [7:0] resp_data;
  logic       resp_valid;

  int n_cmp = 0;
  int n_fail = 0;

  // PUF model knobs
  bit          const_mode = 1'b1;
  bit          const_level = 1'b0;
  bit          use_delay = 1'b0;
  bit          toggle_idle = 1'b0;
  logic [15:0] tab = 16'h0;
  logic [3:0]  sel_hist = 4'h0;

  // Monitor state
  int         arb_cnt = 0;
  bit         arb_wide = 1'b0;
  bit         prev_arb = 1'b0;
  bit         prev_launch = 1'b0;
  logic [3:0] prev_sel = 4'h0;
  logic [3:0] sel_q[$];

  puf_challenge_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .seed          (seed),
    .puf_resp      (puf_resp),
    .resp_ready    (resp_ready),
    .puf_sel       (puf_sel),
    .puf_launch    (puf_launch),
    .puf_arb_reset (puf_arb_reset),
    .busy          (busy),
    .resp_data     (resp_data),
    .resp_valid    (resp_valid)
  );

  always #5 clk = ~clk;

  // Monitor arbiter-side activity and drive the PUF model on the falling edge
  always @(negedge clk) begin
    logic [3:0] s;
    if (puf_launch && prev_launch) begin
      n_cmp++;
      if (puf_sel !== prev_sel) begin
        n_fail++;
        $display("FAIL sel_stable_in_launch: puf_sel=%h held=%h", puf_sel, prev_sel);
      end
    end
    if (puf_arb_reset) begin
      arb_cnt++;
      sel_q.push_back(puf_sel);
      if (prev_arb) arb_wide = 1'b1;
    end
    prev_arb    = puf_arb_reset;
    prev_launch = puf_launch;
    prev_sel    = puf_sel;
    s = use_delay ? sel_hist : puf_sel;
    if (const_mode)                    puf_resp = const_level;
    else if (!puf_launch && toggle_idle) puf_resp = 1'($urandom);
    else                               puf_resp = tab[s];
    sel_hist = puf_sel;
  end

  // Challenge applied for bit i, from the Galois LFSR rule in plain arithmetic
  function automatic int chal_at(input int s, input int i);
    int c;
    c = (s == 0) ? 15 : s;
    for (int k = 0; k < i; k++) c = (c / 2) ^ ((c % 2) ? 12 : 0);
    return c;
  endfunction

  function automatic logic [7:0] model_word(input int s, input logic [15:0] t, input bit cm, input bit lvl);
    logic [7:0] w;
    for (int i = 0; i < R; i++) w[i] = cm ? lvl : t[chal_at(s, i)];
    return w;
  endfunction

  task automatic start_word(input logic [3:0] s);
    @(negedge clk);
    arb_cnt  = 0;
    arb_wide = 1'b0;
    sel_q.delete();
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 lat++;
      if (resp_valid) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic accept();
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({puf_sel, puf_launch, puf_arb_reset, busy, resp_valid, resp_data} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0000",
               {puf_sel, puf_launch, puf_arb_reset, busy, resp_valid, resp_data});
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_cmp++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, resp_valid);
    end
  endtask

  task automatic test_all_ones();
    int lat; bit to;
    const_mode = 1'b1; const_level = 1'b1; toggle_idle = 1'b0;
    start_word(4'h1);
    wait_valid(lat, to);
    n_cmp++;
    if (to || lat != LAT) begin n_fail++; $display("FAIL ones_latency: got %0d (timeout=%0b) want %0d", lat, to, LAT); end
    n_cmp++;
    if (resp_data !== 8'hFF) begin n_fail++; $display("FAIL ones_data: got %h want ff", resp_data); end
    n_cmp++;
    if (arb_cnt != R || arb_wide) begin n_fail++; $display("FAIL ones_arb_pulses: got %0d wide=%0b want %0d single", arb_cnt, arb_wide, R); end
    accept();
    n_cmp++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ones_release: valid=%b busy=%b want 0 0", resp_valid, busy); end
  endtask

  task automatic test_lfsr_model();
    int lat; bit to; logic [7:0] exp;
    const_mode = 1'b0; use_delay = 1'b1; toggle_idle = 1'b0;
    for (int s = 0; s < 16; s++) tab[s] = s[0];
    exp = model_word(1, tab, 1'b0, 1'b0);
    start_word(4'h1);
    wait_valid(lat, to);
    n_cmp++;
    if (to || resp_data !== exp) begin n_fail++; $display("FAIL lfsr_data: got %h want %h", resp_data, exp); end
    n_cmp++;
    if (sel_q.size() != R) begin n_fail++; $display("FAIL lfsr_sel_count: got %0d want %0d", sel_q.size(), R); end
    for (int i = 0; i < sel_q.size(); i++) begin
      n_cmp++;
      if (int'(sel_q[i]) != chal_at(1, i)) begin
        n_fail++;
        $display("FAIL lfsr_sel_%0d: got %h want %h", i, sel_q[i], chal_at(1, i));
      end
    end
    accept();
    use_delay = 1'b0;
  endtask

  task automatic test_zero_seed();
    int lat; bit to; logic [7:0] exp;
    const_mode = 1'b0; toggle_idle = 1'b1;
    tab = 16'($urandom);
    exp = model_word(0, tab, 1'b0, 1'b0);
    start_word(4'h0);
    wait_valid(lat, to);
    n_cmp++;
    if (sel_q.size() == 0 || sel_q[0] !== 4'hF) begin n_fail++; $display("FAIL zero_seed_first_sel: got %h want f", (sel_q.size() != 0) ? sel_q[0] : 4'hx); end
    n_cmp++;
    if (to || resp_data !== exp) begin n_fail++; $display("FAIL zero_seed_data: got %h want %h", resp_data, exp); end
    accept();
  endtask

  task automatic test_random();
    int lat; bit to; logic [7:0] exp; logic [3:0] s;
    const_mode = 1'b0; toggle_idle = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tab = 16'($urandom);
      s   = 4'($urandom_range(0, 15));
      exp = model_word(int'(s), tab, 1'b0, 1'b0);
      start_word(s);
      wait_valid(lat, to);
      n_cmp++;
      if (to || lat != LAT || resp_data !== exp) begin
        n_fail++;
        $display("FAIL random_word_%0d: seed=%h data=%h lat=%0d want data=%h lat=%0d", k, s, resp_data, lat, exp, LAT);
      end
      accept();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to; logic [7:0] exp; bit bad;
    const_mode = 1'b0; toggle_idle = 1'b1;
    tab = 16'($urandom);
    exp = model_word(9, tab, 1'b0, 1'b0);
    start_word(4'h9);
    wait_valid(lat, to);
    bad = to;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 3);
      if (resp_data !== exp || busy !== 1'b1 || resp_valid !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL stall_hold: data=%h busy=%b valid=%b want %h 1 1", resp_data, busy, resp_valid, exp); end
    // start asserted together with the accepting handshake must be dropped
    @(negedge clk) begin start = 1'b1; resp_ready = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; resp_ready = 1'b0; end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || resp_valid !== 1'b0 || puf_arb_reset !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL start_ignored_in_done: busy=%b valid=%b want 0 0", busy, resp_valid); end
  endtask

  task automatic test_reset_mid_word();
    int lat; bit to; bit bad; bit hit; logic [7:0] exp;
    const_mode = 1'b0; toggle_idle = 1'b1;
    tab = 16'($urandom);
    start_word(4'h5);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (arb_cnt == 4 && puf_launch) begin hit = 1'b1; break; end
    end
    n_cmp++;
    if (!hit) begin n_fail++; $display("FAIL reach_bit3_launch: got arb_cnt=%0d want 4 with launch", arb_cnt); end
    #2 reset_n = 1'b0;
    #1 n_cmp++;
    if ({puf_sel, puf_launch, puf_arb_reset, busy, resp_valid, resp_data} !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h want 0000",
               {puf_sel, puf_launch, puf_arb_reset, busy, resp_valid, resp_data});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL no_valid_after_reset: valid=%b busy=%b want 0 0", resp_valid, busy); end
    exp = model_word(6, tab, 1'b0, 1'b0);
    start_word(4'h6);
    wait_valid(lat, to);
    n_cmp++;
    if (to || lat != LAT || resp_data !== exp) begin
      n_fail++;
      $display("FAIL fresh_word_after_reset: data=%h lat=%0d want %h %0d", resp_data, lat, exp, LAT);
    end
    accept();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_all_ones();
    test_lfsr_model();
    test_zero_seed();
    test_random();
    test_backpressure();
    test_reset_mid_word();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
